// File: rtl/nios_led_pkg.sv
// Shared constants for the Nios LED PWM/blink stage.
// Register map, CTRL bit positions, blink state encoding, fade helper.
package nios_led_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_INVERT   = 2;
  localparam int CTRL_FADE     = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  function automatic logic [7:0] fade_step(
    input logic [7:0] act,
    input logic [7:0] req
  );
    if (act < req)
      fade_step = act + 8'd1;
    else if (act > req)
      fade_step = act - 8'd1;
    else
      fade_step = act;
  endfunction

endpackage

// File: rtl/nios_led_prescaler.sv
// PWM clock divider and 8-bit step counter.
// step every PWM_DIV clocks; frame_end when the step counter wraps.
module nios_led_prescaler #(
  parameter int PWM_DIV = 196
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       step,
  output logic       frame_end,
  output logic [7:0] pwm_cnt
);

  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PWM_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign step      = (div_cnt == DIV_MAX);
  assign frame_end = step & (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      if (step) begin
        div_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/nios_led_pwm.sv
// LED brightness PWM and hardware blink behind an Avalon-MM slave.
// Optional duty fading on CTRL[3] when NIOS_LED_PWM_FADE_EN is defined.
module nios_led_pwm
  import nios_led_pkg::*;
#(
  parameter int PWM_DIV = 196,
  parameter int BLINK_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_enable,
  output logic        led_out
);

  logic               en;
  logic               blink_en;
  logic               invert;
  logic               fade;
  logic [7:0]         duty_req;
  logic [7:0]         duty_act;
  logic [7:0]         duty_src;
  logic [BLINK_W-1:0] blink;
  logic [BLINK_W-1:0] fcnt;
  logic [BLINK_W-1:0] half_m1;
  logic [1:0]         state;
  logic [7:0]         pwm_cnt;
  logic               frame_end;
  logic               unused_step;
  logic               unused_wdata;
  logic               wr;
  logic               wr_ctrl;
  logic               wr_duty;
  logic               wr_blink;
  logic               idle_cond;
  logic               last;
  logic               pwm_on;
  logic               gate;

  nios_led_prescaler #(
    .PWM_DIV(PWM_DIV)
  ) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (unused_step),
    .frame_end(frame_end),
    .pwm_cnt  (pwm_cnt)
  );

  assign unused_wdata = ^writedata;

  assign wr       = chipselect & ~write_n;
  assign wr_ctrl  = wr & (address == ADDR_CTRL);
  assign wr_duty  = wr & (address == ADDR_DUTY);
  assign wr_blink = wr & (address == ADDR_BLINK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en       <= 1'b0;
      blink_en <= 1'b0;
      invert   <= 1'b0;
      duty_req <= 8'd0;
      blink    <= '0;
    end else begin
      if (wr_ctrl) begin
        en       <= writedata[CTRL_EN];
        blink_en <= writedata[CTRL_BLINK_EN];
        invert   <= writedata[CTRL_INVERT];
      end
      if (wr_duty)
        duty_req <= writedata[7:0];
      if (wr_blink)
        blink <= writedata[BLINK_W-1:0];
    end
  end

`ifdef NIOS_LED_PWM_FADE_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      fade <= 1'b0;
    else if (wr_ctrl)
      fade <= writedata[CTRL_FADE];
  end
`else
  assign fade = 1'b0;
`endif

  // A DUTY write landing on the frame-end cycle is used for this frame.
  assign duty_src = wr_duty ? writedata[7:0] : duty_req;

  always_ff @(posedge clk) begin
    if (!reset_n)
      duty_act <= 8'd0;
    else if (frame_end)
      duty_act <= fade ? fade_step(duty_act, duty_src) : duty_src;
  end

  assign idle_cond = ~en | ~blink_en | ~in_enable;
  assign half_m1   = (blink == '0) ? '0 : blink - BLINK_W'(1);
  assign last      = (fcnt == half_m1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      fcnt  <= '0;
    end else if (idle_cond) begin
      state <= ST_IDLE;
      fcnt  <= '0;
    end else if (wr_blink || state == ST_IDLE) begin
      state <= ST_ON;
      fcnt  <= '0;
    end else if (frame_end) begin
      if (last) begin
        state <= (state == ST_ON) ? ST_OFF : ST_ON;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + BLINK_W'(1);
      end
    end
  end

  assign pwm_on = (duty_act == 8'hFF) | (pwm_cnt < duty_act);
  assign gate   = in_enable & en & (~blink_en | (state == ST_ON)) & pwm_on;

  always_ff @(posedge clk) begin
    if (!reset_n)
      led_out <= 1'b0;
    else
      led_out <= gate ^ invert;
  end

  always_comb begin
    readdata = 32'd0;
    unique case (1'b1)
      (address == ADDR_CTRL):   readdata = {28'd0, fade, invert, blink_en, en};
      (address == ADDR_DUTY):   readdata = {24'd0, duty_req};
      (address == ADDR_BLINK):  readdata = 32'(blink);
      (address == ADDR_STATUS): readdata = {29'd0, state, led_out};
    endcase
  end

endmodule

// File: tb/tb_nios_led_pwm.sv
// Directed testbench for nios_led_pwm (PWM_DIV=1, BLINK_W=8).
// Covers NIOS_LED_PWM_FADE_EN both defined and undefined.
module tb_nios_led_pwm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_enable;
  logic        led_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] m;

  always #5 clk = ~clk;

  // Reference of the PWM step counter; with PWM_DIV=1 it advances every clock.
  always @(posedge clk) begin
    if (!reset_n) m <= 8'd0;
    else m <= m + 8'd1;
  end

  nios_led_pwm #(
    .PWM_DIV(1),
    .BLINK_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_enable (in_enable),
    .led_out   (led_out)
  );

  typedef struct {
    logic        do_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_m(input logic [7:0] v);
    int n = 0;
    while (m != v && n < 600) begin
      tick();
      n++;
    end
    if (m != v) check("wait_m_timeout", 32'(m), 32'(v));
  endtask

  task automatic wait_lvl(input logic lvl);
    int n = 0;
    while (led_out !== lvl && n < 3000) begin
      tick();
      n++;
    end
    if (led_out !== lvl) check("wait_lvl_timeout", 32'(led_out), 32'(lvl));
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (led_out === lvl && n < 3000) begin
      tick();
      n++;
    end
  endtask

  // Call right after a frame-end edge; sample i reflects pwm_cnt i.
  task automatic sample_frame(input string name, input int duty);
    int bad = 0;
    logic expv;
    for (int i = 0; i < 256; i++) begin
      tick();
      expv = (duty == 255) || (i < duty);
      if (led_out !== expv) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  vec_t vecs[8];
  int   n;
  int   bad;
  int   fexp;
  logic fade_on;

  initial begin
`ifdef NIOS_LED_PWM_FADE_EN
    fade_on = 1'b1;
`else
    fade_on = 1'b0;
`endif
    vecs[0] = '{1'b1, 2'd0, 32'h0000_000F, fade_on ? 32'hF : 32'h7};
    vecs[1] = '{1'b1, 2'd0, 32'hFFFF_FFF0, 32'h0};
    vecs[2] = '{1'b1, 2'd1, 32'h0000_01AB, 32'hAB};
    vecs[3] = '{1'b1, 2'd2, 32'h0000_03FF, 32'hFF};
    vecs[4] = '{1'b1, 2'd2, 32'h0000_0102, 32'h02};
    vecs[5] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[6] = '{1'b0, 2'd1, 32'h0,         32'hAB};
    vecs[7] = '{1'b1, 2'd1, 32'h0,         32'h0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_enable  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    rd_check("rst_ctrl", 2'd0, 32'd0);
    rd_check("rst_duty", 2'd1, 32'd0);
    rd_check("rst_blink", 2'd2, 32'd0);
    rd_check("rst_status", 2'd3, 32'd0);
    check("rst_led", 32'(led_out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) bus_wr(vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    bus_wr(2'd2, 32'd0);
    bus_wr(2'd0, 32'd1);
    bus_wr(2'd1, 32'd255);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (led_out !== 1'b0) bad++;
    end
    check("gated_by_in_enable", 32'(bad), 32'd0);

    in_enable = 1'b1;
    bus_wr(2'd1, 32'd64);
    wait_m(8'd0);
    sample_frame("duty64", 64);
    sample_frame("duty64_repeat", 64);

    bus_wr(2'd1, 32'd0);
    wait_m(8'd0);
    sample_frame("duty0", 0);
    bus_wr(2'd1, 32'd255);
    wait_m(8'd0);
    sample_frame("duty255", 255);

    repeat (10) tick();
    bus_wr(2'd1, 32'd0);
    bad = 0;
    n = 0;
    while (m != 8'd0 && n < 300) begin
      if (led_out !== 1'b1) bad++;
      tick();
      n++;
    end
    check("midframe_hold", 32'(bad), 32'd0);
    check("midframe_last", 32'(led_out), 32'd1);
    tick();
    check("midframe_applied", 32'(led_out), 32'd0);

    wait_m(8'd255);
    check("pre_bypass_off", 32'(led_out), 32'd0);
    bus_wr(2'd1, 32'd255);
    tick();
    check("frame_end_bypass", 32'(led_out), 32'd1);

    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'd3);
    wait_lvl(1'b0);
    wait_lvl(1'b1);
    wait_lvl(1'b0);
    wait_lvl(1'b1);
    rd_check("blink_status_on", 2'd3, 32'd3);
    run_len(1'b1, n);
    check("blink2_high", 32'(n), 32'd512);
    rd_check("blink_status_off", 2'd3, 32'd4);
    run_len(1'b0, n);
    check("blink2_low", 32'(n), 32'd512);

    bus_wr(2'd2, 32'd0);
    wait_lvl(1'b0);
    wait_lvl(1'b1);
    wait_lvl(1'b0);
    wait_lvl(1'b1);
    run_len(1'b1, n);
    check("blink0_high", 32'(n), 32'd256);
    run_len(1'b0, n);
    check("blink0_low", 32'(n), 32'd256);

    wait_lvl(1'b1);
    repeat (5) tick();
    in_enable = 1'b0;
    tick();
    check("drop_in_enable_led", 32'(led_out), 32'd0);
    rd_check("drop_in_enable_idle", 2'd3, 32'd0);
    in_enable = 1'b1;

    bus_wr(2'd0, 32'd5);
    bus_wr(2'd1, 32'd0);
    wait_m(8'd0);
    tick();
    check("invert_duty0", 32'(led_out), 32'd1);

    repeat (37) tick();
    reset_n = 1'b0;
    tick();
    check("midframe_reset_led", 32'(led_out), 32'd0);
    rd_check("midframe_reset_ctrl", 2'd0, 32'd0);
    rd_check("midframe_reset_duty", 2'd1, 32'd0);
    rd_check("midframe_reset_blink", 2'd2, 32'd0);
    rd_check("midframe_reset_status", 2'd3, 32'd0);
    bus_wr(2'd0, 32'd1);
    reset_n = 1'b1;
    rd_check("reset_beats_write", 2'd0, 32'd0);
    tick();

    bus_wr(2'd0, 32'd9);
    rd_check("ctrl_fade_bit", 2'd0, fade_on ? 32'd9 : 32'd1);
    bus_wr(2'd1, 32'd4);
    wait_m(8'd0);
    for (int f = 0; f < 5; f++) begin
      fexp = fade_on ? ((f + 1 < 4) ? f + 1 : 4) : 4;
      sample_frame($sformatf("fade_frame%0d", f), fexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
